// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: increment/branch/dispatch/return-to-fetch with memory wait and halt handling.
// Latency: upc updates one cycle after the controlling microword; mem_req/stall are combinational.
// Backpressure: mem_op without mem_ready stalls the upc; a wait of MEM_TIMEOUT cycles halts with err=1.
module micro_sequencer #(
    parameter logic [4:0] FETCH_ADDR   = 5'd0,
    parameter logic [4:0] ILLEGAL_ADDR = 5'd31,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [4:0] map_addr,
    input  logic [1:0] next_sel,
    input  logic [4:0] branch_addr,
    input  logic       z_flag,
    input  logic       mem_op,
    input  logic       mem_ready,
    output logic [4:0] upc,
    output logic       upc_valid,
    output logic       mem_req,
    output logic       stall,
    output logic       halted,
    output logic       err,
    output logic [7:0] instr_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_MEMWAIT = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    localparam logic [1:0] SEL_INC    = 2'b00;
    localparam logic [1:0] SEL_FETCH  = 2'b01;
    localparam logic [1:0] SEL_BRZ    = 2'b10;
    localparam logic [1:0] SEL_DISP   = 2'b11;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    logic [1:0] state;
    logic [7:0] wait_cnt;

    logic [4:0] adv_upc;
    logic [1:0] adv_state;
    logic       adv_cnt_inc;

    assign upc_valid = (state == S_RUN) || (state == S_MEMWAIT);
    assign halted    = (state == S_HALT);
    assign mem_req   = upc_valid & mem_op;
    assign stall     = upc_valid & mem_op & ~mem_ready;

    // Where the sequencer goes once the current microword is allowed to complete.
    always_comb begin
        adv_upc     = upc + 5'd1;
        adv_state   = S_RUN;
        adv_cnt_inc = 1'b0;
        case (next_sel)
            SEL_INC: begin
                adv_upc = upc + 5'd1;
            end
            SEL_FETCH: begin
                adv_upc     = FETCH_ADDR;
                adv_cnt_inc = 1'b1;
                adv_state   = run ? S_RUN : S_IDLE;
            end
            SEL_BRZ: begin
                adv_upc = z_flag ? branch_addr : (upc + 5'd1);
            end
            SEL_DISP: begin
                if (map_addr == ILLEGAL_ADDR) begin
                    adv_upc   = upc;
                    adv_state = S_HALT;
                end else begin
                    adv_upc = map_addr;
                end
            end
            default: begin
                adv_upc = upc + 5'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            upc       <= FETCH_ADDR;
            err       <= 1'b0;
            instr_cnt <= 8'd0;
            wait_cnt  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    upc <= FETCH_ADDR;
                    if (run) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stall) begin
                        state    <= S_MEMWAIT;
                        wait_cnt <= 8'd1;
                    end else begin
                        state <= adv_state;
                        upc   <= adv_upc;
                        if (adv_cnt_inc) begin
                            instr_cnt <= instr_cnt + 8'd1;
                        end
                    end
                end
                S_MEMWAIT: begin
                    // A ready arriving on the timeout cycle still completes normally.
                    if (mem_ready) begin
                        state    <= adv_state;
                        upc      <= adv_upc;
                        wait_cnt <= 8'd0;
                        if (adv_cnt_inc) begin
                            instr_cnt <= instr_cnt + 8'd1;
                        end
                    end else if (wait_cnt >= TIMEOUT_CNT) begin
                        state    <= S_HALT;
                        err      <= 1'b1;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer using immediate assertions.
module tb_micro_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [4:0] map_addr;
    logic [1:0] next_sel;
    logic [4:0] branch_addr;
    logic       z_flag;
    logic       mem_op;
    logic       mem_ready;
    logic [4:0] upc;
    logic       upc_valid;
    logic       mem_req;
    logic       stall;
    logic       halted;
    logic       err;
    logic [7:0] instr_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    micro_sequencer #(
        .FETCH_ADDR  (5'd0),
        .ILLEGAL_ADDR(5'd31),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .map_addr   (map_addr),
        .next_sel   (next_sel),
        .branch_addr(branch_addr),
        .z_flag     (z_flag),
        .mem_op     (mem_op),
        .mem_ready  (mem_ready),
        .upc        (upc),
        .upc_valid  (upc_valid),
        .mem_req    (mem_req),
        .stall      (stall),
        .halted     (halted),
        .err        (err),
        .instr_cnt  (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_upc"},    32'(upc), 32'd0);
        chk({tag, "_valid"},  32'(upc_valid), 32'd0);
        chk({tag, "_memreq"}, 32'(mem_req), 32'd0);
        chk({tag, "_stall"},  32'(stall), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_err"},    32'(err), 32'd0);
        chk({tag, "_icnt"},   32'(instr_cnt), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; map_addr = 5'd0; next_sel = 2'b00;
        branch_addr = 5'd0; z_flag = 1'b0; mem_op = 1'b1; mem_ready = 1'b0;
        #3;
        chk_reset_outputs("reset");
        mem_op = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_valid", 32'(upc_valid), 32'd0);
        chk("idle_upc", 32'(upc), 32'd0);

        // Sequential increment with wrap: 0..31,0,1
        run = 1'b1; next_sel = 2'b00;
        step();
        for (int i = 0; i <= 33; i++) begin
            chk($sformatf("inc_upc_%0d", i), 32'(upc), 32'(i % 32));
            chk($sformatf("inc_valid_%0d", i), 32'(upc_valid), 32'd1);
            if (i < 33) step();
        end

        // Reach upc=5 via taken branch, then dispatch
        next_sel = 2'b10; z_flag = 1'b1; branch_addr = 5'd5;
        step();
        chk("br_to5", 32'(upc), 32'd5);
        next_sel = 2'b11; map_addr = 5'd9;
        step();
        chk("disp_9", 32'(upc), 32'd9);
        next_sel = 2'b10; branch_addr = 5'd20; z_flag = 1'b1;
        step();
        chk("br_taken_20", 32'(upc), 32'd20);
        branch_addr = 5'd7;
        step();
        chk("br_to7", 32'(upc), 32'd7);
        branch_addr = 5'd20; z_flag = 1'b0;
        step();
        chk("br_not_taken", 32'(upc), 32'd8);

        // Memory wait: ready low 3 cycles, high on the 4th
        next_sel = 2'b00; z_flag = 1'b0; mem_op = 1'b1; mem_ready = 1'b0;
        #1;
        chk("mw_stall0", 32'(stall), 32'd1);
        chk("mw_memreq0", 32'(mem_req), 32'd1);
        for (int k = 1; k <= 2; k++) begin
            step();
            chk($sformatf("mw_hold_upc_%0d", k), 32'(upc), 32'd8);
            chk($sformatf("mw_stall_%0d", k), 32'(stall), 32'd1);
        end
        mem_ready = 1'b1;
        #1;
        chk("mw_stall_ready", 32'(stall), 32'd0);
        step();
        chk("mw_advance", 32'(upc), 32'd9);
        chk("mw_valid", 32'(upc_valid), 32'd1);

        // Zero-wait access
        step();
        chk("zw_advance", 32'(upc), 32'd10);

        // Ready arrives on the 15th MEMWAIT cycle
        mem_ready = 1'b0;
        step();
        for (int k = 1; k < 15; k++) step();
        chk("to_edge_upc", 32'(upc), 32'd10);
        chk("to_edge_halted", 32'(halted), 32'd0);
        mem_ready = 1'b1;
        step();
        chk("to_edge_advance", 32'(upc), 32'd11);
        chk("to_edge_not_halted", 32'(halted), 32'd0);
        chk("to_edge_err", 32'(err), 32'd0);

        // Full timeout: halt with err=1 after 15 MEMWAIT cycles
        mem_ready = 1'b0;
        step();
        for (int k = 1; k < 15; k++) step();
        chk("to_cnt15_halted", 32'(halted), 32'd0);
        step();
        chk("to_halted", 32'(halted), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_valid", 32'(upc_valid), 32'd0);
        chk("to_upc", 32'(upc), 32'd11);
        chk("to_memreq", 32'(mem_req), 32'd0);
        chk("to_stall", 32'(stall), 32'd0);
        mem_ready = 1'b1; next_sel = 2'b01; run = 1'b1;
        step(); step(); step();
        chk("halt_abs_upc", 32'(upc), 32'd11);
        chk("halt_abs_halted", 32'(halted), 32'd1);

        // Asynchronous reset out of HALT
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_halt");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset pulsed during MEMWAIT
        run = 1'b1; next_sel = 2'b00; mem_op = 1'b0; mem_ready = 1'b0;
        step();
        step();
        chk("pre_mw_upc", 32'(upc), 32'd1);
        mem_op = 1'b1;
        step();
        chk("in_mw_stall", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mw");
        @(negedge clk);
        rst_n = 1'b1;
        mem_op = 1'b0;

        // Illegal dispatch halts with err=0
        step();
        chk("post_rst_run_upc", 32'(upc), 32'd0);
        chk("post_rst_run_valid", 32'(upc_valid), 32'd1);
        next_sel = 2'b11; map_addr = 5'd31;
        step();
        chk("ill_halted", 32'(halted), 32'd1);
        chk("ill_err", 32'(err), 32'd0);
        chk("ill_valid", 32'(upc_valid), 32'd0);
        map_addr = 5'd9; mem_op = 1'b1;
        step(); step();
        chk("ill_hold", 32'(halted), 32'd1);
        chk("ill_memreq", 32'(mem_req), 32'd0);
        chk("ill_upc_frozen", 32'(upc), 32'd0);
        mem_op = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ill_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // run dropped mid-instruction is honoured only at the fetch boundary
        run = 1'b1; next_sel = 2'b00;
        step();
        step();
        chk("rd_upc1", 32'(upc), 32'd1);
        run = 1'b0;
        step();
        chk("rd_upc2", 32'(upc), 32'd2);
        chk("rd_still_valid", 32'(upc_valid), 32'd1);
        next_sel = 2'b01;
        step();
        chk("rd_icnt", 32'(instr_cnt), 32'd1);
        chk("rd_idle_valid", 32'(upc_valid), 32'd0);
        chk("rd_idle_upc", 32'(upc), 32'd0);
        step();
        chk("rd_idle_stays", 32'(upc_valid), 32'd0);
        chk("rd_icnt_hold", 32'(instr_cnt), 32'd1);

        // Instruction counter wraps after 256 completions
        run = 1'b1;
        step();
        chk("wrap_run_icnt", 32'(instr_cnt), 32'd1);
        for (int k = 0; k < 254; k++) step();
        chk("wrap_255", 32'(instr_cnt), 32'd255);
        step();
        chk("wrap_0", 32'(instr_cnt), 32'd0);
        chk("wrap_upc", 32'(upc), 32'd0);
        chk("wrap_valid", 32'(upc_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter FETCH_ADDR, default 5'd0: control-store address of the common fetch microroutine.
REQ-002 Parameter ILLEGAL_ADDR, default 5'd31: map address reserved for undefined opcodes.
REQ-003 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for a memory handshake; legal range 1..255.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 run  input  1  level enable for program execution.
REQ-007 map_addr  input  5  dispatch address from the opcode mapper (IR[7:4] decoded).
REQ-008 next_sel  input  2  next-address select of the current microword: 00 increment, 01 return-to-fetch, 10 branch-if-zero, 11 dispatch.
REQ-009 branch_addr  input  5  branch target field of the current microword.
REQ-010 z_flag  input  1  ALU zero flag.
REQ-011 mem_op  input  1  current microword performs a memory access (LOAD/STORE/fetch).
REQ-012 mem_ready  input  1  memory access complete this cycle.
REQ-013 upc  output  5  registered micro-PC (control-store address).
REQ-014 upc_valid  output  1  upc is executing this cycle.
REQ-015 mem_req  output  1  memory request, combinational.
REQ-016 stall  output  1  datapath hold, combinational.
REQ-017 halted  output  1  sequencer in HALT.
REQ-018 err  output  1  halt cause was a memory timeout (0 = illegal opcode).
REQ-019 instr_cnt  output  8  count of completed instructions.

Function
REQ-020 States SHALL be IDLE, RUN, MEMWAIT, HALT, one-hot or binary at implementer's choice.
REQ-021 IDLE: upc=FETCH_ADDR, upc_valid=0; run=1 sampled -> RUN next cycle with upc=FETCH_ADDR.
REQ-022 RUN/MEMWAIT: upc_valid=1; HALT and IDLE: upc_valid=0.
REQ-023 mem_req SHALL equal mem_op while upc_valid=1, else 0.
REQ-024 stall SHALL equal mem_op & ~mem_ready while upc_valid=1, else 0.
REQ-025 In RUN, when stall=0 the upc SHALL advance next cycle per next_sel; when stall=1 upc SHALL hold and state -> MEMWAIT.
REQ-026 next_sel=00: upc+1, wrapping 31 -> 0.
REQ-027 next_sel=10: branch_addr if z_flag=1, else upc+1 (same wrap).
REQ-028 next_sel=11: map_addr, unless map_addr==ILLEGAL_ADDR -> HALT with err=0.
REQ-029 next_sel=01: instr_cnt+1 (wrap 255 -> 0); upc=FETCH_ADDR and stay RUN if run=1, else -> IDLE.
REQ-030 run SHALL only be honoured at next_sel=01 boundaries; deassertion mid-instruction SHALL NOT abort it.
REQ-031 MEMWAIT: upc held, 8-bit wait counter increments each cycle from 1 at entry; mem_ready=1 -> advance per next_sel exactly as RUN and return to RUN (or IDLE/HALT per REQ-028/029).
REQ-032 MEMWAIT: counter reaching MEM_TIMEOUT with mem_ready=0 -> HALT, err=1; mem_ready=1 in the same cycle SHALL win (normal advance).
REQ-033 Wait counter SHALL clear on every MEMWAIT exit.
REQ-034 HALT SHALL be absorbing: halted=1, upc frozen, mem_req=0, inputs ignored until reset.
REQ-035 Zero-wait access (mem_op=1, mem_ready=1 in RUN) SHALL advance without entering MEMWAIT.

Reset
REQ-036 rst_n=0 SHALL immediately, asynchronously force IDLE, upc=FETCH_ADDR, upc_valid=0, halted=0, err=0, instr_cnt=0, wait counter=0; mem_req=stall=0.
REQ-037 Reset asserted mid-MEMWAIT or in HALT SHALL abandon the operation with no residual state; release synchronous to next rising edge.

Verification
REQ-038 run=1, next_sel=00 for 33 cycles from upc=0 -> upc 0,1..31,0,1; upc_valid=1 throughout.
REQ-039 At upc=5, next_sel=11, map_addr=5'd9 -> upc=9 next cycle; map_addr=5'd31 -> halted=1, err=0, upc_valid=0, held until rst_n=0.
REQ-040 next_sel=10, branch_addr=5'd20: z_flag=1 -> upc=20; z_flag=0 from upc=7 -> upc=8.
REQ-041 mem_op=1, mem_ready low 3 cycles then high -> stall=1 for 3 cycles, upc held, advances on 4th; MEM_TIMEOUT=15, mem_ready never high -> halted=1, err=1 after 15 MEMWAIT cycles; ready on cycle 15 -> normal advance.
REQ-042 run dropped mid-instruction, then next_sel=01 -> instr_cnt+1, state IDLE, upc=0; 256 completed instructions -> instr_cnt wraps to 0.
REQ-043 rst_n pulsed low during MEMWAIT -> all outputs at reset values within the same cycle, no clock edge required.
